pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 The block SHALL derive localparam GROUPS = WIDTH/4, the number of 4-bit lookahead groups and pipeline stages.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand set present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have ports A and B, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port c_in, input, 1 bit: the carry-in for add mode.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects A+B+c_in; 1 selects A-B, computed as A+~B+1 with c_in ignored.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a result is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port S, output, WIDTH bits: the sum or difference.
REQ-013 The block SHALL have port c_out, output, 1 bit: the carry out of the MSB; in sub mode 1 means no borrow.
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 The block SHALL have ports PG and GG, output, 1 bit each: word-level propagate and generate of the effective operands A and B' (B' = sub ? ~B : B).

Function
REQ-016 Each group k (bits 4k+3..4k) SHALL compute bit p=a^b' and g=a&b', lookahead carries c1..c4 from the group carry-in, group P = &p and group G = g3|p3g2|p3p2g1|p3p2p1g0.
REQ-017 Stage k SHALL register the group-k sum bits and the carry into group k+1; group 0 carry-in = sub ? 1 : c_in.
REQ-018 Operand bits of groups above k, plus the running word P/G, SHALL be carried forward in the stage-k register (input skew), so each group computes in its own stage.
REQ-019 Running word P/G SHALL combine as P = Pk & Pprev and G = Gk | (Pk & Gprev), giving PG = AND of all group P and GG = carry-in-independent word generate.
REQ-020 Summed bits already computed SHALL be carried forward so that S, c_out, ovf, PG and GG appear together from the last stage register.
REQ-021 ovf SHALL equal the carry into the MSB XOR c_out.
REQ-022 Global advance SHALL be adv = !out_valid | out_ready, and in_ready SHALL equal adv combinationally.
REQ-023 On adv, every stage SHALL shift forward one position, each with its own valid bit; stage 0 loads only when in_valid && in_ready, and otherwise loads a bubble (valid 0).
REQ-024 When adv=0 (out_valid && !out_ready), all stages SHALL hold, and S, c_out, ovf, PG and GG SHALL remain stable.
REQ-025 Latency: an operand set accepted at edge N SHALL be presented with out_valid=1 after edge N+GROUPS-1 (GROUPS=1 gives a one-cycle registered result).
REQ-026 Throughput SHALL be one result per cycle while out_ready=1, with no bubble inserted between back-to-back transfers.
REQ-027 Results SHALL exit in acceptance order; no set is dropped or duplicated under any out_ready pattern.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH, with carry/borrow reported only on c_out.

Reset
REQ-029 When rst_n=0 at a clock edge, all stage valid bits SHALL clear to 0, and S, c_out, ovf, PG and GG SHALL clear to 0.
REQ-030 A reset mid-operation SHALL discard all in-flight sets, and out_valid SHALL be 0 in the cycle after that edge.
REQ-031 During reset, in_ready SHALL follow REQ-022 using the cleared state, but no set SHALL be accepted on an edge where rst_n=0.
REQ-032 There SHALL be no asynchronous reset path.

Verification (WIDTH=8, GROUPS=2 unless noted)
REQ-033 A=FF, B=01, c_in=0, sub=0 -> S=00, c_out=1, ovf=0, PG=0, GG=1, out_valid after edge N+1.
REQ-034 A=0F, B=F0, c_in=1, sub=0 -> S=00, c_out=1, PG=1, GG=0; then A=7F, B=01, c_in=0 -> S=80, ovf=1, c_out=0.
REQ-035 A=05, B=07, sub=1 -> S=FE, c_out=0, ovf=0; then A=80, B=01, sub=1 -> S=7F, ovf=1, c_out=1.
REQ-036 Ten back-to-back sets with out_ready=1 -> ten results on consecutive cycles, in order; then out_ready=0 for 3 cycles -> in_ready=0, outputs frozen, no loss on release.
REQ-037 rst_n=0 for one edge while two sets are in flight -> out_valid=0 the next cycle, neither set is ever emitted, and a set sent afterwards completes with correct values.
REQ-038 A random sweep at WIDTH=4, 16 and 64 with random in_valid/out_ready SHALL match a reference model (A±B, c_out, ovf, PG, GG) with zero mismatches.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder/subtractor built from 4-bit carry-lookahead
// groups, one group resolved per pipeline stage, with valid/ready flow control.
// Operands enter together and are skewed through the pipe so that group k is summed
// in stage k. The final stage register drives S, c_out, ovf, PG and GG together.
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             ovf,
  output logic             PG,
  output logic             GG
);

  localparam int GROUPS = WIDTH / 4;
  // Number of intermediate stage registers; kept at least 1 so the array is legal.
  localparam int MIDS   = (GROUPS > 1) ? GROUPS - 1 : 1;

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 between 4 and 64");
  end

  // Result of one 4-bit lookahead group.
  typedef struct packed {
    logic [3:0] s;    // group sum bits
    logic       c3;   // carry into the group's top bit
    logic       c4;   // carry out of the group
    logic       gp;   // group propagate
    logic       gg;   // group generate
  } cla4_t;

  // Contents of an intermediate stage register. The full operand words travel with
  // the set; only the groups above the current stage are still needed downstream.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;      // operand A
    logic [WIDTH-1:0] b;      // effective operand B' (inverted in sub mode)
    logic [WIDTH-1:0] sum;    // sum bits of the groups resolved so far
    logic             carry;  // carry into the next group
    logic             cmsb;   // carry into the top bit of the last resolved group
    logic             pw;     // running word propagate
    logic             gw;     // running word generate
  } mid_t;

  // Contents of the final (output) stage register.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             pw;
    logic             gw;
  } fin_t;

  // One 4-bit carry-lookahead group: carries c1..c4 from the group carry-in.
  function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    cla4_t      r;
    // NOTE: functions and always_comb use blocking '=' so each line sees the value
    // computed on the line above; flops use '<=' so all stages sample the old state.
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    r.gp = &p;
    r.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    c[4] = r.gg | (r.gp & c[0]);
    r.s  = p ^ c[3:0];
    r.c3 = c[3];
    r.c4 = c[4];
    return r;
  endfunction

  // Resolve group k of a set: fill in its sum bits, pass its carry on and fold its
  // P/G into the running word P/G.
  function automatic mid_t step(input mid_t cur, input int k);
    mid_t  r;
    cla4_t g;
    g = cla4(cur.a[4*k +: 4], cur.b[4*k +: 4], cur.carry);
    r = cur;
    r.sum[4*k +: 4] = g.s;
    r.carry         = g.c4;
    r.cmsb          = g.c3;
    r.pw            = g.gp & cur.pw;
    r.gw            = g.gg | (g.gp & cur.gw);
    return r;
  endfunction

  mid_t mid_q [MIDS];     // stage registers 0 .. GROUPS-2
  fin_t fin_q;            // stage register GROUPS-1, drives the outputs
  mid_t head;             // incoming set, shaped like a stage register
  mid_t src [GROUPS];     // input to the group logic of each stage
  mid_t nxt [GROUPS];     // output of the group logic of each stage
  logic adv;

  // The whole pipe moves only when the output slot is empty or being taken.
  assign adv      = !fin_q.valid || out_ready;
  assign in_ready = adv;

  // Shape the incoming operand set: invert B and force carry-in for subtraction.
  always_comb begin
    // NOTE: every field gets a value on every pass, so no latch can be inferred.
    head       = '0;
    head.valid = in_valid;
    head.a     = A;
    head.b     = sub ? ~B : B;
    head.carry = sub ? 1'b1 : c_in;
    head.pw    = 1'b1;   // identity for the running AND
    head.gw    = 1'b0;   // identity for the running generate
  end

  assign src[0] = head;
  for (genvar k = 1; k < GROUPS; k++) begin : g_link
    assign src[k] = mid_q[k-1];
  end

  for (genvar k = 0; k < GROUPS; k++) begin : g_cla
    assign nxt[k] = step(src[k], k);
  end

  // Intermediate stages: shift forward together on adv, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: valid bits alone govern flow; the datapath is cleared too so the
      // pipe holds no stale operand data after reset.
      for (int i = 0; i < MIDS; i++) begin
        mid_q[i] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < GROUPS - 1; i++) begin
        mid_q[i] <= nxt[i];
      end
    end
  end

  // Final stage: capture the completed word, carry-out and signed overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fin_q <= '0;
    end else if (adv) begin
      fin_q.valid <= nxt[GROUPS-1].valid;
      fin_q.sum   <= nxt[GROUPS-1].sum;
      fin_q.c_out <= nxt[GROUPS-1].carry;
      fin_q.ovf   <= nxt[GROUPS-1].cmsb ^ nxt[GROUPS-1].carry;
      fin_q.pw    <= nxt[GROUPS-1].pw;
      fin_q.gw    <= nxt[GROUPS-1].gw;
    end
  end

  assign out_valid = fin_q.valid;
  assign S         = fin_q.sum;
  assign c_out     = fin_q.c_out;
  assign ovf       = fin_q.ovf;
  assign PG        = fin_q.pw;
  assign GG        = fin_q.gw;

endmodule
